// File: rtl/seg7_scan_mux_if.sv
// Purpose: bundle of datapath/control signals between the numeric datapath and the scanned 7-segment driver.
// Latency: none (wires only).
// Backpressure: load/load_ack handshake; load_ack pulses when captured data reaches the display.
// Ports: enable, lamp_test, load, bcd_in, dp_in, blank_mask (master -> slave);
//        load_ack, seg, dp, an (slave -> master).
interface seg7_scan_mux_if #(
    parameter int N_DIGITS = 8
);
    logic                  enable;
    logic                  lamp_test;
    logic                  load;
    logic [4*N_DIGITS-1:0] bcd_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_mask;
    logic                  load_ack;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output enable, lamp_test, load, bcd_in, dp_in, blank_mask,
        input  load_ack, seg, dp, an
    );

    modport slave (
        input  enable, lamp_test, load, bcd_in, dp_in, blank_mask,
        output load_ack, seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Purpose: time-multiplexed BCD driver for N common-anode 7-segment digits (one shared decoder).
// Latency: seg/dp/an/load_ack registered, one cycle after scan position or control change.
// Backpressure: new data is staged on load and only shown at a frame boundary, acknowledged by load_ack.
// Ports: clk, rst_n (async active-low); bus (seg7_scan_mux_if.slave) carries controls, data,
//        load_ack and the active-low seg {g,f,e,d,c,b,a}, dp and an pins.
// Option: define SEG7_LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module seg7_scan_mux #(
    parameter int N_DIGITS = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_mux_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  frame_end;

    logic [4*N_DIGITS-1:0] stg_bcd;
    logic [N_DIGITS-1:0]   stg_dp;
    logic [N_DIGITS-1:0]   stg_blank;
    logic                  pending;

    logic [4*N_DIGITS-1:0] dsp_bcd;
    logic [N_DIGITS-1:0]   dsp_dp;
    logic [N_DIGITS-1:0]   dsp_blank;

    logic [N_DIGITS-1:0]   lz_blank;
    logic [3:0]            cur_bcd;
    logic [N_DIGITS-1:0]   sel;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [N_DIGITS-1:0]   an_d;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [N_DIGITS-1:0]   an_q;
    logic                  ack_q;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0011000;
            default: p = 7'b0111111;   // non-BCD codes show a dash
        endcase
        return p;
    endfunction

    assign tick      = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = tick && (idx == IW'(N_DIGITS - 1));

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Staging / display handshake. A load on the frame-boundary cycle keeps
    // pending set so the new value follows one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_bcd   <= '0;
            stg_dp    <= '0;
            stg_blank <= '0;
            pending   <= 1'b0;
            dsp_bcd   <= '0;
            dsp_dp    <= '0;
            dsp_blank <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= frame_end && pending;
            if (frame_end && pending) begin
                dsp_bcd   <= stg_bcd;
                dsp_dp    <= stg_dp;
                dsp_blank <= stg_blank;
                pending   <= 1'b0;
            end
            if (bus.load) begin
                stg_bcd   <= bus.bcd_in;
                stg_dp    <= bus.dp_in;
                stg_blank <= bus.blank_mask;
                pending   <= 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit i is a leading zero when it and every more significant digit are 0.
    logic upper_zero;
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (dsp_bcd[4*i +: 4] == 4'd0);
            lz_blank[i] = upper_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign cur_bcd = dsp_bcd[{idx, 2'b00} +: 4];
    assign sel     = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);

    // Output priority: enable, then lamp test, then blanking, then decoded digit.
    // Anodes stay off for the first cycle of each slot to avoid ghosting.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (bus.enable) begin
            an_d = (cnt == '0) ? '1 : sel;
            if (bus.lamp_test) begin
                seg_d = 7'h00;
                dp_d  = 1'b0;
            end else if (!(dsp_blank[idx] || lz_blank[idx])) begin
                seg_d = decode(cur_bcd);
                dp_d  = ~dsp_dp[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;
    assign bus.an       = an_q;
    assign bus.load_ack = ack_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Purpose: self-checking bench for seg7_scan_mux (4 digits, 4-cycle slots) against a cycle-count model.
// Latency: model predicts each registered output one cycle ahead from slot arithmetic.
// Backpressure: load/load_ack pulses predicted from frame-boundary arithmetic.
module tb_seg7_scan_mux;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FR = ND * SD;

    logic clk;
    logic rst_n;

    seg7_scan_mux_if #(.N_DIGITS(ND)) bus ();

    seg7_scan_mux #(.N_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        logic [6:0] seg;
    } vec_t;
    vec_t vec [16];

    int checks = 0;
    int errors = 0;

    // Model state: cycles since reset release, staged and shown frames.
    int          cyc;
    logic [15:0] st_bcd, sh_bcd;
    logic [3:0]  st_dp, sh_dp, st_blank, sh_blank;
    bit          pend_m;
    logic [6:0]  seg_seen [ND];
    int          ack_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; st_bcd = '0; sh_bcd = '0; st_dp = '0; sh_dp = '0;
        st_blank = '0; sh_blank = '0; pend_m = 0;
    endtask

    function automatic bit lz_dark(input int d, input logic [15:0] v);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        return (d >= 1) && ((v >> (4*d)) == 16'd0);
`else
        return (d < 0) && (v == 16'hFFFF);
`endif
    endfunction

    // Predict one cycle, advance the clock, compare.
    task automatic step();
        int         slot_pos;
        int         dig;
        int         code;
        bit         boundary;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ack;
        slot_pos = cyc % SD;
        dig      = (cyc / SD) % ND;
        boundary = (cyc % FR) == FR - 1;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (bus.enable) begin
            if (slot_pos != 0) e_an = 4'hF ^ (4'(1) << dig);
            if (bus.lamp_test) begin
                e_seg = 7'h00; e_dp = 1'b0;
            end else if (!(sh_blank[dig] || lz_dark(dig, sh_bcd))) begin
                code  = int'((sh_bcd >> (4*dig)) & 16'hF);
                e_seg = vec[code].seg;
                e_dp  = ~sh_dp[dig];
            end
        end
        e_ack = boundary && pend_m;
        if (boundary && pend_m) begin
            sh_bcd = st_bcd; sh_dp = st_dp; sh_blank = st_blank; pend_m = 0;
        end
        if (bus.load) begin
            st_bcd = bus.bcd_in; st_dp = bus.dp_in; st_blank = bus.blank_mask; pend_m = 1;
        end
        cyc++;
        @(posedge clk);
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("load_ack", 32'(bus.load_ack), 32'(e_ack));
        if (bus.load_ack) ack_cnt++;
        for (int d = 0; d < ND; d++)
            if (bus.an == (4'hF ^ (4'(1) << d))) seg_seen[d] = bus.seg;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_once(input logic [15:0] b, input logic [3:0] p, input logic [3:0] m);
        bus.bcd_in = b; bus.dp_in = p; bus.blank_mask = m; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
        chk({tag, "_an"}, 32'(bus.an), 32'hF);
        chk({tag, "_ack"}, 32'(bus.load_ack), 32'h0);
    endtask

    initial begin
        vec[0]  = '{4'd0,  7'b1000000}; vec[1]  = '{4'd1,  7'b1111001};
        vec[2]  = '{4'd2,  7'b0100100}; vec[3]  = '{4'd3,  7'b0110000};
        vec[4]  = '{4'd4,  7'b0011001}; vec[5]  = '{4'd5,  7'b0010010};
        vec[6]  = '{4'd6,  7'b0000010}; vec[7]  = '{4'd7,  7'b1111000};
        vec[8]  = '{4'd8,  7'b0000000}; vec[9]  = '{4'd9,  7'b0011000};
        vec[10] = '{4'd10, 7'b0111111}; vec[11] = '{4'd11, 7'b0111111};
        vec[12] = '{4'd12, 7'b0111111}; vec[13] = '{4'd13, 7'b0111111};
        vec[14] = '{4'd14, 7'b0111111}; vec[15] = '{4'd15, 7'b0111111};
        for (int d = 0; d < ND; d++) seg_seen[d] = 7'h55;

        rst_n = 1'b0;
        bus.enable = 1'b1; bus.lamp_test = 1'b0; bus.load = 1'b0;
        bus.bcd_in = '0; bus.dp_in = '0; bus.blank_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        model_reset();
        rst_n = 1'b1;

        // Free-running scan after reset, all zeros shown.
        run(40);

        // Mid-frame load: exactly one ack.
        ack_cnt = 0;
        while (cyc % FR != 6) step();
        load_once(16'h9321, 4'b0010, 4'b0000);
        run(2 * FR);
        chk("single_ack_count", 32'(ack_cnt), 32'd1);

        // Load held into the frame-boundary cycle with a second value.
        ack_cnt = 0;
        while (cyc % FR != FR - 2) step();
        bus.bcd_in = 16'h1234; bus.dp_in = 4'b0000; bus.blank_mask = 4'b0000; bus.load = 1'b1;
        step();
        bus.bcd_in = 16'h0007;
        step();
        bus.load = 1'b0;
        run(3 * FR);
        chk("double_ack_count", 32'(ack_cnt), 32'd2);

        // Non-BCD code plus a blanked digit.
        load_once(16'h00C0, 4'b0000, 4'b0100);
        run(3 * FR);
        chk("dash_digit1", 32'(seg_seen[1]), 32'h3F);
        chk("blank_digit2", 32'(seg_seen[2]), 32'h7F);

        // Lamp test, then enable dropped.
        bus.lamp_test = 1'b1;
        run(FR + 4);
        bus.enable = 1'b0;
        run(6);
        bus.enable = 1'b1; bus.lamp_test = 1'b0;
        run(6);

        // Leading zeros.
        load_once(16'h0040, 4'b0000, 4'b0000);
        run(3 * FR);
        chk("lz_digit1", 32'(seg_seen[1]), 32'h19);
        chk("lz_digit0", 32'(seg_seen[0]), 32'h40);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        chk("lz_digit3", 32'(seg_seen[3]), 32'h7F);
        chk("lz_digit2", 32'(seg_seen[2]), 32'h7F);
`else
        chk("lz_digit3", 32'(seg_seen[3]), 32'h40);
        chk("lz_digit2", 32'(seg_seen[2]), 32'h40);
`endif

        // Decoder table, one value in every digit.
        for (int i = 0; i < 16; i++) begin
            load_once({4{vec[i].val}}, 4'b0000, 4'b0000);
            run(36);
            chk($sformatf("decode_%0d", i), 32'(seg_seen[0]), 32'(vec[i].seg));
        end

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            bus.enable     = ($urandom % 8) != 0;
            bus.lamp_test  = ($urandom % 16) == 0;
            bus.load       = ($urandom % 10) == 0;
            bus.bcd_in     = 16'($urandom);
            bus.dp_in      = 4'($urandom);
            bus.blank_mask = 4'($urandom % 4 == 0 ? $urandom : 0);
            step();
        end
        bus.enable = 1'b1; bus.lamp_test = 1'b0; bus.load = 1'b0;

        // Reset mid-slot with a load pending: outputs reset at once, no ack afterwards.
        while (cyc % FR != 5) step();
        load_once(16'h5555, 4'b1111, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        ack_cnt = 0;
        run(3 * FR);
        chk("no_ack_after_reset", 32'(ack_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
